// File: rtl/parallel_out_display.sv
// Shows the 8-bit parallel output register value in decimal on four 7-segment digits using a
// sequential double-dabble converter. Define PAROUT_SIGNED_EN for two's-complement input with a sign digit.
module parallel_out_display #(
    parameter bit ACTIVE_LOW    = 1'b1,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       upd,
    input  logic [7:0] data_in,
    output logic [6:0] hex0,
    output logic [6:0] hex1,
    output logic [6:0] hex2,
    output logic [6:0] hex3,
    output logic       busy
);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    localparam logic [6:0] SegBlank = ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [6:0] SegZero  = ACTIVE_LOW ? 7'h40 : 7'h3F;

    // Segment pattern for a BCD code; bit0=a .. bit6=g, polarity applied on return.
    function automatic logic [6:0] seg_enc(input logic [3:0] code, input logic blank);
        logic [6:0] lit;
        case (code)
            4'd0:    lit = 7'h3F;
            4'd1:    lit = 7'h06;
            4'd2:    lit = 7'h5B;
            4'd3:    lit = 7'h4F;
            4'd4:    lit = 7'h66;
            4'd5:    lit = 7'h6D;
            4'd6:    lit = 7'h7D;
            4'd7:    lit = 7'h07;
            4'd8:    lit = 7'h7F;
            4'd9:    lit = 7'h6F;
            default: lit = 7'h00;
        endcase
        if (blank) begin
            lit = 7'h00;
        end
        return ACTIVE_LOW ? ~lit : lit;
    endfunction

    state_e      state_q, state_d;
    logic [7:0]  sr_q, sr_d;
    logic [9:0]  bcd_q, bcd_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        pend_q, pend_d;
    logic [7:0]  pend_data_q, pend_data_d;
    logic [6:0]  hex0_q, hex0_d;
    logic [6:0]  hex1_q, hex1_d;
    logic [6:0]  hex2_q, hex2_d;
    logic [6:0]  hex3_q, hex3_d;

    logic        start;
    logic [7:0]  src_data;
    logic [7:0]  src_mag;
    logic [9:0]  bcd_adj;
    logic [3:0]  dig_hund;
    logic [3:0]  dig_tens;
    logic [3:0]  dig_ones;
    logic        blank_hund;
    logic        blank_tens;

    // A direct strobe outranks a buffered one; the buffer is dropped in that case.
    assign start    = (state_q == StIdle) && (upd || pend_q);
    assign src_data = upd ? data_in : pend_data_q;

`ifdef PAROUT_SIGNED_EN
    logic neg_q, neg_d;
    logic src_neg;

    assign src_neg = src_data[7];
    assign src_mag = src_neg ? (~src_data + 8'd1) : src_data;
`else
    assign src_mag = src_data;
`endif

    assign dig_hund   = {2'b00, bcd_q[9:8]};
    assign dig_tens   = bcd_q[7:4];
    assign dig_ones   = bcd_q[3:0];
    assign blank_hund = BLANK_LEADING && (dig_hund == 4'd0);
    assign blank_tens = blank_hund && (dig_tens == 4'd0);

    // Hundreds never exceeds 2, so only the tens and units nibbles need the add-3 correction.
    always_comb begin
        bcd_adj = bcd_q;
        if (bcd_q[3:0] >= 4'd5) begin
            bcd_adj[3:0] = bcd_q[3:0] + 4'd3;
        end
        if (bcd_q[7:4] >= 4'd5) begin
            bcd_adj[7:4] = bcd_q[7:4] + 4'd3;
        end
    end

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        bcd_d       = bcd_q;
        cnt_d       = cnt_q;
        pend_d      = pend_q;
        pend_data_d = pend_data_q;
        hex0_d      = hex0_q;
        hex1_d      = hex1_q;
        hex2_d      = hex2_q;
        hex3_d      = hex3_q;
`ifdef PAROUT_SIGNED_EN
        neg_d       = neg_q;
`endif

        if (upd && (state_q != StIdle)) begin
            pend_d      = 1'b1;
            pend_data_d = data_in;
        end else if (start) begin
            pend_d = 1'b0;
        end

        case (state_q)
            StIdle: begin
                if (start) begin
                    sr_d    = src_mag;
                    bcd_d   = 10'd0;
                    cnt_d   = 3'd0;
                    state_d = StShift;
`ifdef PAROUT_SIGNED_EN
                    neg_d   = src_neg;
`endif
                end
            end
            StShift: begin
                {bcd_d, sr_d} = {bcd_adj, sr_q} << 1;
                cnt_d         = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                hex0_d  = seg_enc(dig_ones, 1'b0);
                hex1_d  = seg_enc(dig_tens, blank_tens);
                hex2_d  = seg_enc(dig_hund, blank_hund);
`ifdef PAROUT_SIGNED_EN
                hex3_d  = neg_q ? (ACTIVE_LOW ? 7'h3F : 7'h40) : SegBlank;
`else
                hex3_d  = SegBlank;
`endif
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            sr_q        <= 8'd0;
            bcd_q       <= 10'd0;
            cnt_q       <= 3'd0;
            pend_q      <= 1'b0;
            pend_data_q <= 8'd0;
            hex0_q      <= SegZero;
            hex1_q      <= SegBlank;
            hex2_q      <= SegBlank;
            hex3_q      <= SegBlank;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            bcd_q       <= bcd_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            pend_data_q <= pend_data_d;
            hex0_q      <= hex0_d;
            hex1_q      <= hex1_d;
            hex2_q      <= hex2_d;
            hex3_q      <= hex3_d;
        end
    end

`ifdef PAROUT_SIGNED_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            neg_q <= 1'b0;
        end else begin
            neg_q <= neg_d;
        end
    end
`endif

    assign hex0 = hex0_q;
    assign hex1 = hex1_q;
    assign hex2 = hex2_q;
    assign hex3 = hex3_q;
    assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_parallel_out_display.sv
// Directed bench for parallel_out_display with a scoreboard of expected digit patterns.
// Honours PAROUT_SIGNED_EN when the design is built with it.
module tb_parallel_out_display;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       upd = 1'b0;
    logic [7:0] data_in = 8'd0;
    logic [6:0] hex0, hex1, hex2, hex3;
    logic       busy;
    logic [6:0] nb_hex0, nb_hex1, nb_hex2, nb_hex3;
    logic       nb_busy;

    int n_assert = 0;
    int n_fail   = 0;

    logic [27:0] exp_q[$];

    localparam logic [6:0] Blank = 7'h7F;
    localparam logic [6:0] Minus = 7'h3F;

    logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    logic [7:0] extra_vals [6] = '{8'd0, 8'd10, 8'd99, 8'd128, 8'hFF, 8'd205};

    always #5 clk = ~clk;

    parallel_out_display u_dut (
        .clk     (clk),
        .reset   (reset),
        .upd     (upd),
        .data_in (data_in),
        .hex0    (hex0),
        .hex1    (hex1),
        .hex2    (hex2),
        .hex3    (hex3),
        .busy    (busy)
    );

    parallel_out_display #(
        .ACTIVE_LOW    (1'b1),
        .BLANK_LEADING (1'b0)
    ) u_dut_nb (
        .clk     (clk),
        .reset   (reset),
        .upd     (upd),
        .data_in (data_in),
        .hex0    (nb_hex0),
        .hex1    (nb_hex1),
        .hex2    (nb_hex2),
        .hex3    (nb_hex3),
        .busy    (nb_busy)
    );

    // Expected {hex3, hex2, hex1, hex0} for an input byte.
    function automatic logic [27:0] model(input logic [7:0] v, input bit blank_lead);
        int mag;
        bit neg;
        int h, t, u;
        logic [6:0] s0, s1, s2, s3;
        neg = 1'b0;
        mag = int'(v);
`ifdef PAROUT_SIGNED_EN
        if (v[7]) begin
            neg = 1'b1;
            mag = 256 - int'(v);
        end
`endif
        h  = mag / 100;
        t  = (mag / 10) % 10;
        u  = mag % 10;
        s0 = seg_tab[u];
        s1 = seg_tab[t];
        s2 = seg_tab[h];
        if (blank_lead && h == 0) s2 = Blank;
        if (blank_lead && h == 0 && t == 0) s1 = Blank;
        s3 = neg ? Minus : Blank;
        return {s3, s2, s1, s0};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Strobe one value; a strobe while busy replaces any buffered one, as the design does.
    task automatic do_upd(input logic [7:0] v);
        logic [27:0] e;
        e = model(v, 1'b1);
        if (busy && exp_q.size() >= 2) exp_q[exp_q.size() - 1] = e;
        else exp_q.push_back(e);
        upd     = 1'b1;
        data_in = v;
        tick();
        upd     = 1'b0;
        data_in = 8'($urandom_range(0, 255));
    endtask

    task automatic wait_done(input bit check_lat, input string tag);
        int n;
        logic [27:0] held;
        logic [27:0] e;
        n    = 0;
        held = {hex3, hex2, hex1, hex0};
        while (busy && n < 40) begin
            n++;
            if (n == 5) check({tag, " hold"}, 32'({hex3, hex2, hex1, hex0}), 32'(held));
            tick();
        end
        if (busy) begin
            check({tag, " timeout"}, 32'(busy), 32'd0);
            return;
        end
        if (check_lat) check({tag, " latency"}, 32'(n), 32'd9);
        check({tag, " sb nonempty"}, 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, " digits"}, 32'({hex3, hex2, hex1, hex0}), 32'(e));
        end
    endtask

    initial begin
        int busy_seen;

        #1 reset = 1'b1;
        #1;
        check("reset hex0", 32'(hex0), 32'h40);
        check("reset hex1", 32'(hex1), 32'h7F);
        check("reset hex2", 32'(hex2), 32'h7F);
        check("reset hex3", 32'(hex3), 32'h7F);
        check("reset busy", 32'(busy), 32'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        do_upd(8'd255);
        wait_done(1'b1, "v255");
`ifndef PAROUT_SIGNED_EN
        check("v255 literal", 32'({hex3, hex2, hex1, hex0}), 32'({7'h7F, 7'h24, 7'h12, 7'h12}));
`else
        check("vFF literal", 32'({hex3, hex0}), 32'({7'h3F, 7'h79}));
`endif

        do_upd(8'd7);
        wait_done(1'b1, "v7");
        check("v7 literal", 32'({hex2, hex1, hex0}), 32'({7'h7F, 7'h7F, 7'h78}));
        check("v7 noblank", 32'({nb_hex2, nb_hex1, nb_hex0}), 32'({7'h40, 7'h40, 7'h78}));
        check("v7 noblank model", 32'({nb_hex3, nb_hex2, nb_hex1, nb_hex0}),
              32'(model(8'd7, 1'b0)));

        // Strobes during a conversion: 15 is overwritten by 42 before it can start.
        do_upd(8'd100);
        tick();
        tick();
        do_upd(8'd15);
        tick();
        do_upd(8'd42);
        wait_done(1'b0, "v100");
        check("v100 literal", 32'({hex2, hex1, hex0}), 32'({7'h79, 7'h40, 7'h40}));
        tick();
        check("pending restart busy", 32'(busy), 32'd1);
        wait_done(1'b1, "v42");
        check("v42 literal", 32'({hex1, hex0}), 32'({7'h19, 7'h24}));
        check("sb drained", 32'(exp_q.size()), 32'd0);

`ifdef PAROUT_SIGNED_EN
        do_upd(8'h80);
        wait_done(1'b1, "v80");
        check("v80 literal", 32'({hex3, hex2, hex1, hex0}), 32'({7'h3F, 7'h79, 7'h24, 7'h00}));
`endif

        foreach (extra_vals[i]) begin
            do_upd(extra_vals[i]);
            wait_done(1'b1, $sformatf("extra%0d", i));
        end

        // Reset in the middle of a conversion that also has a buffered strobe.
        do_upd(8'd200);
        tick();
        do_upd(8'd33);
        reset = 1'b1;
        #1;
        check("midreset hex0", 32'(hex0), 32'h40);
        check("midreset hex1", 32'(hex1), 32'h7F);
        check("midreset hex2", 32'(hex2), 32'h7F);
        check("midreset hex3", 32'(hex3), 32'h7F);
        check("midreset busy", 32'(busy), 32'd0);
        exp_q.delete();
        tick();
        tick();
        reset = 1'b0;
        busy_seen = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (busy) busy_seen++;
        end
        check("post reset idle", 32'(busy_seen), 32'd0);
        check("post reset display", 32'({hex3, hex2, hex1, hex0}),
              32'({7'h7F, 7'h7F, 7'h7F, 7'h40}));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
